// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit-side byte buffer placed directly in front of uart_tx. CPU I/O
// writes are queued in a small FIFO, and a drain FSM hands the bytes to
// uart_tx one at a time using its tx_send / tx_ready handshake. This keeps
// the CPU from stalling on the serial bit rate. Fill level and a sticky
// overflow flag are exported for a status port.
//
// Parameters:
//   DEPTH_LOG2   log2 of the FIFO depth (DEPTH = 2**DEPTH_LOG2 bytes)
//
// Ports:
//   clk           system clock
//   reset_n       synchronous reset, active-low
//   wr_data       byte to enqueue
//   wr_en         enqueue strobe, one byte per cycle while high
//   clr_overflow  clears the sticky overflow flag
//   full          FIFO holds DEPTH entries
//   empty         FIFO holds no entries
//   count         number of entries currently held (0..DEPTH)
//   overflow      sticky: a write arrived while full and was dropped
//   busy          FIFO not empty, or a byte is still being handed off/sent
//   tx_data       byte presented to uart_tx
//   tx_send       send request to uart_tx
//   tx_ready      uart_tx idle/ready indication
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic [7:0]            tx_data,
  output logic                  tx_send,
  input  logic                  tx_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACK  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  send_next;
  logic                  load_data;
  logic                  pop;
  logic                  wr_accept;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  // Full/empty come straight from the registered count, so a write is judged
  // against the occupancy at the start of the cycle, ignoring any same-cycle pop.
  assign full      = (count == COUNT_FULL);
  assign empty     = (count == '0);
  assign wr_accept = wr_en & ~full;
  assign busy      = ~empty | (state != S_IDLE);

  // Storage array. Contents need no reset: count/pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH. Count is kept separately so that full
  // and empty can be told apart when the pointers are equal; a simultaneous
  // push and pop leaves it unchanged while both pointers move.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow. A dropped write in the same cycle as a clear keeps the
  // flag set, so software never loses evidence of a drop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Drain FSM, next-state logic. The byte is only popped once uart_tx has
  // acknowledged it by dropping tx_ready, so a send issued while uart_tx is
  // momentarily not looking cannot lose data. After the pop we wait for
  // uart_tx to finish its frame before considering the next byte.
  always_comb begin
    state_next = state;
    send_next  = 1'b0;
    load_data  = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && tx_ready) begin
          load_data  = 1'b1;
          send_next  = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        send_next = 1'b1;
        if (!tx_ready) begin
          send_next  = 1'b0;
          pop        = 1'b1;
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Drain FSM state register plus the registered handshake outputs. tx_data
  // is captured once when the send starts and then held stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state   <= state_next;
      tx_send <= send_next;
      if (load_data) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of uart_tx in the Z80 I/O path. It accepts bytes from the CPU I/O-write logic into a FIFO, then drains them one at a time into uart_tx using uart_tx's tx_send/tx_ready handshake. This decouples CPU writes from the serial bit rate. It also reports fill level and overflow for a status port.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries of 8 bits)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous reset, active-low
wr_data  input  8  byte to enqueue
wr_en  input  1  enqueue strobe; one byte per clk cycle while high
clr_overflow  input  1  clears the overflow flag
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  number of entries currently held
overflow  output  1  sticky; a write was dropped
busy  output  1  high when FIFO is not empty or a byte is in flight
tx_data  output  8  byte presented to uart_tx
tx_send  output  1  send request to uart_tx
tx_ready  input  1  uart_tx idle/ready indication

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk. All state changes on posedge clk.
- Reset values:
  - tx_send=0, tx_data=8'h00, overflow=0, count=0, empty=1, full=0, busy=0.
  - Read/write pointers = 0; state = S_IDLE.
- Storage: DEPTH x 8 register array with wr_ptr and rd_ptr, each DEPTH_LOG2 bits.
  - Pointers wrap modulo DEPTH by natural overflow.
  - count is tracked separately, range 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0). Both are registered/derived from registered count.
- Write:
  - If wr_en=1 and full=0 at the edge: mem[wr_ptr]<=wr_data, wr_ptr++, count++.
  - If wr_en=1 and full=1: byte dropped, pointers unchanged, overflow<=1.
  - full is judged before any same-cycle pop, so a write while full is dropped even if a pop occurs in the same cycle.
- Overflow flag:
  - clr_overflow=1 clears it.
  - If clr_overflow and a dropped write coincide, set wins (overflow=1).
- Pop and simultaneous events:
  - A pop (rd_ptr++, count--) occurs only in the S_WAIT_ACK transition described below.
  - Accepted write and pop in the same cycle: count unchanged, both pointers advance.
- Drain FSM (uart_tx latches tx_data on the first idle cycle it sees tx_send=1, drops tx_ready, and returns to idle only after its stop bit has completed and tx_send is low):
  - S_IDLE: if empty=0 and tx_ready=1, then tx_data<=mem[rd_ptr], tx_send<=1, go S_WAIT_ACK. Otherwise stay.
  - S_WAIT_ACK: tx_send held 1 and tx_data held stable. When tx_ready=0: tx_send<=0, pop FIFO, go S_WAIT_DONE.
  - S_WAIT_DONE: when tx_ready=1, go S_IDLE.
  - Any unused encoding goes to S_IDLE.
- busy = ~empty | (state != S_IDLE).
- Latency:
  - An accepted write makes empty=0 after its edge.
  - If tx_ready=1, tx_send rises on the following edge.
  - Minimum gap between consecutive tx_send rises is one S_IDLE cycle after tx_ready returns high.
- The byte is popped only after uart_tx acknowledges it (tx_ready low), so no byte is lost if tx_ready is low when a send is requested.
- Reset mid-operation: all state returns to reset values on the next edge. Queued and in-flight bytes are discarded. uart_tx shares reset_n.
- tx_ready low while in S_IDLE (e.g., right after reset): no send is issued until it goes high.

Test Plan:
- Reset with wr_en=1, wr_data=8'hAA → all outputs at reset values; nothing enqueued; count=0 after reset_n rises.
- Write 8'h41 to empty FIFO with tx_ready=1 (model uart_tx, 115200 baud at 27 MHz) → tx_send rises one edge after empty falls with tx_data=8'h41; tx_send falls after tx_ready falls; count returns to 0.
- Burst write 8'h30..8'h3F (16 bytes) while tx_ready held 0 → full=1, count=16; a 17th write (8'h40) sets overflow=1 and is dropped. Release tx_ready → bytes 8'h30..8'h3F sent in order; 8'h40 is never sent.
- Write on the same cycle as the S_WAIT_ACK pop with count=3 → count stays 3 and both pointers advance. Cross pointer wrap (push 20 bytes in total) and check the order is preserved.
- clr_overflow coincident with a dropped write while full → overflow stays 1. clr_overflow alone on the next cycle → overflow=0.
- Assert reset_n=0 while in S_WAIT_DONE with count=5 → next edge tx_send=0, count=0, busy=0; after release, no byte is transmitted.
